// File: rtl/dpram_bwc_if.sv
// Bus bundle for the dual-port byte-write RAM: two read/write ports,
// the clear request and busy, and the collision strobe.
interface dpram_bwc_if #(
   parameter int DW = 32,
   parameter int NB = 4,
   parameter int AW = 4
);
   logic          clr;
   logic          busy;
   logic          rEn0, rEn1;
   logic [NB-1:0] wEn0, wEn1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wData0, wData1;
   logic [DW-1:0] rData0, rData1;
   logic          rValid0, rValid1;
   logic          coll;

   modport master (
      output clr, rEn0, rEn1, wEn0, wEn1, addr0, addr1, wData0, wData1,
      input  busy, rData0, rData1, rValid0, rValid1, coll
   );

   modport slave (
      input  clr, rEn0, rEn1, wEn0, wEn1, addr0, addr1, wData0, wData1,
      output busy, rData0, rData1, rValid0, rValid1, coll
   );
endinterface

// File: rtl/dpram_bwc.sv
// True dual-port RAM with per-lane write enables, selectable read-during-write
// behaviour, optional output register and a hardware clear sweep.
module dpram_bwc #(
   parameter int    MD         = 16,
   parameter int    DW         = 32,
   parameter int    BW         = 8,
   parameter string RDW        = "OLD",
   parameter int    OREG       = 0,
   parameter int    CLR_ON_RST = 1,
   localparam int   NB         = DW / BW,
   localparam int   AW         = $clog2(MD)
) (
   input logic        clk,
   input logic        rst_n,
   dpram_bwc_if.slave bus
);
   typedef enum logic {IDLE, CLEAR} state_t;

   state_t  state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic    busy;

   logic [DW-1:0] mem [MD];

   logic [1:0]         re;
   logic [1:0][NB-1:0] we;
   logic [1:0][AW-1:0] ad;
   logic [1:0][DW-1:0] wd, rd_now, rd_s1;
   logic [1:0]         v_s1;
   logic               coll_q;

   assign busy     = (state_q == CLEAR);
   assign bus.busy = busy;

   // User traffic is masked at the source so the sweep owns the array.
   assign re = {bus.rEn1, bus.rEn0} & {2{~busy}};
   assign we = {bus.wEn1 & {NB{~busy}}, bus.wEn0 & {NB{~busy}}};
   assign ad = {bus.addr1, bus.addr0};
   assign wd = {bus.wData1, bus.wData0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE:  if (bus.clr) state_d = CLEAR;
         CLEAR: begin
            if (cnt_q == AW'(MD - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Port 0 is written last so it wins overlapping lanes on a shared address.
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[cnt_q] <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (we[1][b]) mem[ad[1]][b*BW +: BW] <= wd[1][b*BW +: BW];
            if (we[0][b]) mem[ad[0]][b*BW +: BW] <= wd[0][b*BW +: BW];
         end
      end
   end

   // Only a port's own lanes bypass in NEW mode; the other port is never seen.
   always_comb begin
      rd_now = '0;
      for (int p = 0; p < 2; p++) begin
         rd_now[p] = mem[ad[p]];
         for (int b = 0; b < NB; b++)
            if (RDW == "NEW" && we[p][b]) rd_now[p][b*BW +: BW] = wd[p][b*BW +: BW];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_s1  <= '0;
         v_s1   <= '0;
         coll_q <= 1'b0;
      end else begin
         v_s1   <= re;
         for (int p = 0; p < 2; p++)
            if (re[p]) rd_s1[p] <= rd_now[p];
         coll_q <= (ad[0] == ad[1]) && (|we[0]) && (|we[1]);
      end
   end

   generate
      if (OREG != 0) begin : g_oreg
         logic [1:0][DW-1:0] rd_s2;
         logic [1:0]         v_s2;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_s2 <= '0;
               v_s2  <= '0;
            end else begin
               v_s2 <= v_s1;
               for (int p = 0; p < 2; p++)
                  if (v_s1[p]) rd_s2[p] <= rd_s1[p];
            end
         end
         assign bus.rData0  = rd_s2[0];
         assign bus.rData1  = rd_s2[1];
         assign bus.rValid0 = v_s2[0];
         assign bus.rValid1 = v_s2[1];
      end else begin : g_noreg
         assign bus.rData0  = rd_s1[0];
         assign bus.rData1  = rd_s1[1];
         assign bus.rValid0 = v_s1[0];
         assign bus.rValid1 = v_s1[1];
      end
   endgenerate

   assign bus.coll = coll_q;
endmodule

// File: doc/dpram_bwc.md
DPRAM_BWC -- requirements
Module: dpram_bwc

Interface
REQ-001 SHALL have parameter MD, default 16, memory depth in words (≥2, any integer).
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter BW, default 8, byte-lane width; DW divisible by BW; NB=DW/BW lanes.
REQ-004 SHALL have parameter RDW, default "OLD", same-port read-during-write mode: "OLD" or "NEW".
REQ-005 SHALL have parameter OREG, default 0, extra output register stage (0/1).
REQ-006 SHALL have parameter CLR_ON_RST, default 1, hardware clear runs after reset release when 1.
REQ-007 SHALL have one clock; reset is asynchronous and active-low: clk  in  1  clock, all logic on rising edge.
REQ-008 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-009 SHALL have clr  in  1  clear-memory request pulse.
REQ-010 SHALL have busy  out  1  clear sweep in progress.
REQ-011 SHALL have rEn0/rEn1  in  1  read enable, ports 0/1.
REQ-012 SHALL have wEn0/wEn1  in  NB  per-lane write enable, ports 0/1.
REQ-013 SHALL have addr0/addr1  in  `log2(MD)  address, ports 0/1.
REQ-014 SHALL have wData0/wData1  in  DW  write data, ports 0/1.
REQ-015 SHALL have rData0/rData1  out  DW  read data, ports 0/1.
REQ-016 SHALL have rValid0/rValid1  out  1  rData valid strobe, ports 0/1.
REQ-017 SHALL have coll  out  1  write-write collision strobe.

Function
REQ-018 SHALL write only lanes whose wEn bit is set; other lanes hold prior contents.
REQ-019 SHALL return a read issued at cycle t (rEn=1) on rData with rValid=1 at t+1+OREG; rValid=0 otherwise, rData holds last value.
REQ-020 SHALL, for same-port read+write to one address: RDW="OLD" returns pre-write word; RDW="NEW" returns pre-write word merged with enabled written lanes.
REQ-021 SHALL return pre-write data on cross-port read of an address written by the other port in the same cycle.
REQ-022 SHALL, when both ports write one address in one cycle, write port-0 lanes on overlapping lanes, each port's lanes on non-overlapping lanes, and pulse coll for one cycle at t+1.
REQ-023 SHALL not pulse coll for differing addresses or zero-overlap-free cases where either wEn is all-zero.
REQ-024 SHALL implement FSM IDLE/CLEAR; IDLE->CLEAR on clr=1; CLEAR->IDLE after writing address MD-1.
REQ-025 SHALL in CLEAR write zero to one address per cycle, 0 up to MD-1 (MD cycles), busy=1 throughout.
REQ-026 SHALL ignore rEn/wEn on both ports while busy=1 (no write, rValid=0, coll=0); in-flight OREG reads issued before CLEAR still complete.
REQ-027 SHALL ignore clr while in CLEAR (no restart).
REQ-028 SHALL deassert busy the cycle after address MD-1 is cleared; user accesses accepted that cycle.
REQ-029 SHALL not require MD power of two; sweep counter stops at MD-1, no wrap past it.

Reset
REQ-030 SHALL, while rst_n=0: rData0/1=0, rValid0/1=0, coll=0, OREG pipeline cleared, sweep counter=0.
REQ-031 SHALL enter CLEAR with busy=1 on reset when CLR_ON_RST=1, else IDLE with busy=0; memory contents not reset asynchronously.
REQ-032 SHALL, on reset asserted mid-CLEAR, restart sweep from address 0 after release (CLR_ON_RST=1) or stop in IDLE (CLR_ON_RST=0).

Verification (MD=16, DW=32, BW=8)
REQ-033 SHALL cover: reset release, CLR_ON_RST=1 -> busy=1 exactly 16 cycles; then read addr 0..15 -> all 0x00000000, rValid at t+1.
REQ-034 SHALL cover: port0 write 0xAABBCCDD addr 3 wEn=1111, then wEn=0010 data 0x00001100 -> read addr 3 = 0xAABB11DD.
REQ-035 SHALL cover: addr 5=0x1; port0 write 0x2 with rEn0 same cycle -> rData0=0x1 (OLD), 0x2 (NEW); port1 read addr 5 same cycle -> 0x1.
REQ-036 SHALL cover: both ports write addr 7, wEn0=0011 data 0x00001111, wEn1=1111 data 0x22222222 -> addr 7=0x22221111, coll=1 for one cycle.
REQ-037 SHALL cover: clr at cycle 0 with writes during sweep, reset at sweep cycle 8 -> writes dropped, sweep restarts at 0, all reads 0 after busy falls.
REQ-038 SHALL cover: OREG=1, back-to-back reads addr 1,2,3 -> rValid at t+2, data in order, no bubbles.
